// File: rtl/maze_pkg.sv
// Shared types and sizes for the maze ROM arbitration slice.
package maze_pkg;

  localparam int ROM_ADDR_W = 11;
  localparam int ROM_DATA_W = 16;

  typedef enum logic [1:0] {
    G_IDLE,
    G_PEND,
    G_FLIGHT
  } game_arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_GAME
  } rom_owner_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Owner-tag delay line matching the ROM read latency, so returning data can be
// steered to whichever requester issued the read.
module rom_tag_pipe
  import maze_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       i_clr,
  input  rom_owner_t i_tag,
  output rom_owner_t o_tag
);

  rom_owner_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    // NOTE: every stage is cleared, not just the head; a stale tag would turn
    // pre-reset ROM data into a valid pulse after reset.
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= OWN_NONE;
    end else begin
      stage_q[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/maze_rom_arbiter.sv
// Shares the single-port maze ROM between the streaming display fetcher and the
// occasional game wall check, with a starvation bound on the game side.
module maze_rom_arbiter
  import maze_pkg::*;
#(
  parameter int ADDR_W       = ROM_ADDR_W,
  parameter int DATA_W       = ROM_DATA_W,
  parameter int ROM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_game_req,
  input  logic [ADDR_W-1:0] i_game_addr,
  output logic              o_game_busy,
  output logic              o_game_valid,
  output logic [DATA_W-1:0] o_game_data,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_starve
);

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  game_arb_state_t   state_q;
  logic [ADDR_W-1:0] game_addr_q;
  logic [CNT_W-1:0]  starve_q;
  logic              force_game;
  rom_owner_t        win_tag;
  rom_owner_t        out_tag;

  // Per-cycle arbitration: a starved game beats the display, otherwise the
  // display has priority and the game fills idle slots.
  always_comb begin
    force_game = (state_q == G_PEND) && (starve_q == CNT_W'(STARVE_LIMIT - 1));
    win_tag    = OWN_NONE;
    if (force_game)              win_tag = OWN_GAME;
    else if (i_disp_req)         win_tag = OWN_DISP;
    else if (state_q == G_PEND)  win_tag = OWN_GAME;
  end

  assign o_rom_en    = (win_tag != OWN_NONE);
  assign o_rom_addr  = (win_tag == OWN_DISP) ? i_disp_addr :
                       (win_tag == OWN_GAME) ? game_addr_q : '0;
  assign o_game_busy = (state_q != G_IDLE);

  rom_tag_pipe #(
    .DEPTH (ROM_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .i_clr (rst),
    .i_tag (win_tag),
    .o_tag (out_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= G_IDLE;
      game_addr_q  <= '0;
      starve_q     <= '0;
      o_starve     <= 1'b0;
      o_disp_valid <= 1'b0;
      o_disp_data  <= '0;
      o_game_valid <= 1'b0;
      o_game_data  <= '0;
    end else begin
      o_starve     <= force_game;
      o_disp_valid <= (out_tag == OWN_DISP);
      o_game_valid <= (out_tag == OWN_GAME);
      if (out_tag == OWN_DISP) o_disp_data <= i_rom_data;
      if (out_tag == OWN_GAME) o_game_data <= i_rom_data;

      // Only cycles where a pending game loses to the display count toward starvation.
      if (win_tag == OWN_GAME)
        starve_q <= '0;
      else if ((state_q == G_PEND) && (win_tag == OWN_DISP))
        starve_q <= starve_q + 1'b1;

      unique case (state_q)
        G_IDLE: begin
          if (i_game_req) begin
            game_addr_q <= i_game_addr;
            state_q     <= G_PEND;
          end
        end
        G_PEND: begin
          if (win_tag == OWN_GAME) state_q <= G_FLIGHT;
        end
        G_FLIGHT: begin
          if (out_tag == OWN_GAME) state_q <= G_IDLE;
        end
        default: state_q <= G_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Drives two arbiters (ROM latency 1 and 3) with shared stimulus and checks them
// against a cycle-indexed expectation schedule built from the arbitration rules.
module tb_maze_rom_arbiter;
  import maze_pkg::*;

  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int SL   = 8;
  localparam int MAXC = 4096;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  typedef struct {
    logic  greq;
    addr_t gaddr;
    logic  en;
    addr_t raddr;
    logic  busy;
    logic  gv;
    data_t gd;
  } tv_t;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst = 1'b1;
  logic  disp_req = 1'b0;
  logic  game_req = 1'b0;
  addr_t disp_addr = '0;
  addr_t game_addr = '0;

  logic  dv_w[2], gv_w[2], busy_w[2], st_w[2], en_w[2];
  data_t dd_w[2], gd_w[2], rd_w[2];
  addr_t ra_w[2];

  maze_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1), .STARVE_LIMIT(SL)) u_l1 (
    .clk(clk), .rst(rst),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_valid(dv_w[0]), .o_disp_data(dd_w[0]),
    .i_game_req(game_req), .i_game_addr(game_addr),
    .o_game_busy(busy_w[0]), .o_game_valid(gv_w[0]), .o_game_data(gd_w[0]),
    .o_rom_en(en_w[0]), .o_rom_addr(ra_w[0]), .i_rom_data(rd_w[0]),
    .o_starve(st_w[0])
  );

  maze_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(3), .STARVE_LIMIT(SL)) u_l3 (
    .clk(clk), .rst(rst),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_valid(dv_w[1]), .o_disp_data(dd_w[1]),
    .i_game_req(game_req), .i_game_addr(game_addr),
    .o_game_busy(busy_w[1]), .o_game_valid(gv_w[1]), .o_game_data(gd_w[1]),
    .o_rom_en(en_w[1]), .o_rom_addr(ra_w[1]), .i_rom_data(rd_w[1]),
    .o_starve(st_w[1])
  );

  function automatic data_t rom_word(input addr_t a);
    return DW'({a, 5'b0});
  endfunction

  // ROM primitives: data appears ROM_LATENCY cycles after the address.
  data_t rom1_q;
  data_t rom3_q[3];
  always @(posedge clk) begin
    rom1_q    <= rom_word(ra_w[0]);
    rom3_q[0] <= rom_word(ra_w[1]);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rd_w[0] = rom1_q;
  assign rd_w[1] = rom3_q[2];

  // Reference model: game request bookkeeping plus an expected-output schedule.
  int    lat[2] = '{1, 3};
  bit    m_pend[2], m_fl[2], m_forced[2];
  int    m_gdue[2], m_starve[2], m_win[2];
  addr_t m_gaddr[2], m_addr[2];
  bit    e_dv[2][MAXC], e_gv[2][MAXC], e_st[2][MAXC];
  data_t e_rd[2][MAXC];
  data_t h_dd[2], h_gd[2];

  int c = 0;
  bit known = 1'b0;
  int total = 0;
  int bad = 0;
  int cnt_dv[2], cnt_gv[2], cnt_st[2], last_gv[2];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, k, c, act, exp);
    end
  endtask

  task automatic begin_cycle();
    for (int k = 0; k < 2; k++) begin
      if (dv_w[k] === 1'b1) cnt_dv[k]++;
      if (st_w[k] === 1'b1) cnt_st[k]++;
      if (gv_w[k] === 1'b1) begin
        cnt_gv[k]++;
        last_gv[k] = c;
      end
      if (known) begin
        if (e_dv[k][c]) h_dd[k] = e_rd[k][c];
        if (e_gv[k][c]) h_gd[k] = e_rd[k][c];
        check("disp_valid", k, dv_w[k], e_dv[k][c]);
        check("disp_data",  k, dd_w[k], h_dd[k]);
        check("game_valid", k, gv_w[k], e_gv[k][c]);
        check("game_data",  k, gd_w[k], h_gd[k]);
        check("starve",     k, st_w[k], e_st[k][c]);
        check("game_busy",  k, busy_w[k], m_pend[k] || m_fl[k]);
      end
    end
  endtask

  task automatic drive(input logic r, input logic dreq, input addr_t da,
                       input logic greq, input addr_t ga);
    rst = r; disp_req = dreq; disp_addr = da; game_req = greq; game_addr = ga;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_forced[k] = m_pend[k] && (m_starve[k] == SL - 1);
      if (m_forced[k])   m_win[k] = 2;
      else if (dreq)     m_win[k] = 1;
      else if (m_pend[k]) m_win[k] = 2;
      else               m_win[k] = 0;
      m_addr[k] = (m_win[k] == 1) ? da : (m_win[k] == 2) ? m_gaddr[k] : '0;
      if (known && !r) begin
        check("rom_en",   k, en_w[k], m_win[k] != 0);
        check("rom_addr", k, ra_w[k], m_addr[k]);
      end
    end
  endtask

  task automatic end_cycle();
    bit was_rst;
    bit idle;
    int due;
    was_rst = rst;
    for (int k = 0; k < 2; k++) begin
      if (was_rst) begin
        m_pend[k] = 0; m_fl[k] = 0; m_starve[k] = 0;
        h_dd[k] = '0; h_gd[k] = '0;
        for (int j = c + 1; j < MAXC; j++) begin
          e_dv[k][j] = 0; e_gv[k][j] = 0; e_st[k][j] = 0;
        end
      end else begin
        idle = !m_pend[k] && !m_fl[k];
        due  = c + lat[k] + 1;
        if (m_win[k] != 0) begin
          e_rd[k][due] = rom_word(m_addr[k]);
          if (m_win[k] == 1) e_dv[k][due] = 1;
          else               e_gv[k][due] = 1;
        end
        e_st[k][c+1] = m_forced[k];
        if (m_win[k] == 2)                    m_starve[k] = 0;
        else if (m_win[k] == 1 && m_pend[k])  m_starve[k]++;
        if (m_fl[k] && (c + 1 == m_gdue[k])) m_fl[k] = 0;
        if (m_win[k] == 2) begin
          m_pend[k] = 0; m_fl[k] = 1; m_gdue[k] = due;
        end
        if (idle && game_req) begin
          m_pend[k] = 1; m_gaddr[k] = game_addr;
        end
      end
    end
    @(posedge clk);
    if (was_rst) known = 1'b1;
    c++;
    @(negedge clk);
  endtask

  task automatic cyc(input logic r, input logic dreq, input addr_t da,
                     input logic greq, input addr_t ga);
    begin_cycle();
    drive(r, dreq, da, greq, ga);
    end_cycle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    tv_t tbl[5];
    int  s_st[2], s_dv[2], s_gv[2];
    int  t0;

    tbl[0] = '{1'b1, 11'h045, 1'b0, 11'h000, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 11'h000, 1'b1, 11'h045, 1'b1, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 16'h08A0};
    tbl[4] = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 16'h08A0};

    @(negedge clk);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);

    // Game-only transaction on the latency-1 arbiter, starting from reset state.
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      check("tbl_busy",  0, busy_w[0], tbl[i].busy);
      check("tbl_gvalid", 0, gv_w[0], tbl[i].gv);
      check("tbl_gdata", 0, gd_w[0], tbl[i].gd);
      drive(1'b0, 1'b0, '0, tbl[i].greq, tbl[i].gaddr);
      check("tbl_rom_en",   0, en_w[0], tbl[i].en);
      check("tbl_rom_addr", 0, ra_w[0], tbl[i].raddr);
      end_cycle();
    end
    idle_cycles(4);

    // Display streaming with a pending game: one forced slot, one lost display word.
    for (int k = 0; k < 2; k++) begin s_st[k] = cnt_st[k]; s_dv[k] = cnt_dv[k]; end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, addr_t'(i), i == 2, 11'h123);
    idle_cycles(8);
    for (int k = 0; k < 2; k++) begin
      check("starve_pulses", k, cnt_st[k] - s_st[k], 1);
      check("disp_words",    k, cnt_dv[k] - s_dv[k], 19);
    end

    // A one-cycle display gap lets the game through without forcing.
    for (int k = 0; k < 2; k++) begin s_st[k] = cnt_st[k]; s_dv[k] = cnt_dv[k]; end
    for (int i = 0; i < 12; i++) cyc(1'b0, i != 5, addr_t'(100 + i), i == 2, 11'h2AA);
    idle_cycles(8);
    for (int k = 0; k < 2; k++) begin
      check("gap_starve",     k, cnt_st[k] - s_st[k], 0);
      check("gap_disp_words", k, cnt_dv[k] - s_dv[k], 11);
    end

    // Extra game pulses while busy are ignored.
    for (int k = 0; k < 2; k++) s_gv[k] = cnt_gv[k];
    cyc(1'b0, 1'b0, '0, 1'b1, 11'h111);
    cyc(1'b0, 1'b0, '0, 1'b1, 11'h222);
    cyc(1'b0, 1'b0, '0, 1'b1, 11'h333);
    idle_cycles(8);
    for (int k = 0; k < 2; k++) begin
      check("busy_ignore_count", k, cnt_gv[k] - s_gv[k], 1);
      check("busy_ignore_data",  k, gd_w[k], 16'h2220);
    end

    // Reset the cycle after a game issue: in-flight read is discarded.
    cyc(1'b0, 1'b0, '0, 1'b1, 11'h055);
    cyc(1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 2; k++) s_gv[k] = cnt_gv[k];
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    begin_cycle();
    for (int k = 0; k < 2; k++) begin
      check("rst_dvalid", k, dv_w[k], 0);
      check("rst_ddata",  k, dd_w[k], 0);
      check("rst_gvalid", k, gv_w[k], 0);
      check("rst_gdata",  k, gd_w[k], 0);
      check("rst_busy",   k, busy_w[k], 0);
      check("rst_starve", k, st_w[k], 0);
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 2; k++) check("rst_rom_en", k, en_w[k], 0);
    end_cycle();
    idle_cycles(6);
    for (int k = 0; k < 2; k++) check("rst_no_gvalid", k, cnt_gv[k] - s_gv[k], 0);
    cyc(1'b0, 1'b0, '0, 1'b1, 11'h077);
    idle_cycles(6);
    for (int k = 0; k < 2; k++) begin
      check("post_rst_count", k, cnt_gv[k] - s_gv[k], 1);
      check("post_rst_data",  k, gd_w[k], 16'h0EE0);
    end

    // Uncontended request-to-valid latency: ROM_LATENCY + 2.
    last_gv[0] = -1; last_gv[1] = -1;
    t0 = c;
    cyc(1'b0, 1'b0, '0, 1'b1, 11'h3C3);
    idle_cycles(10);
    check("game_latency", 0, last_gv[0] - t0, 3);
    check("game_latency", 1, last_gv[1] - t0, 5);

    // Interleaved display and game traffic.
    for (int i = 0; i < 16; i++)
      cyc(1'b0, (i % 2) == 0, addr_t'(11'h400 + i), (i % 5) == 1, addr_t'(11'h600 + i));
    idle_cycles(8);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, addr_t'($urandom),
          $urandom_range(0, 9) == 0, addr_t'($urandom));
    idle_cycles(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
